// File: rtl/mac_accumulator.sv
// Signed int8 dot-product MAC with saturating accumulator and per-channel
// requantize parameter bank; results carry the bias/scale/zero point of their channel.
module mac_accumulator #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int BIAS_W  = 32,
  parameter int SCALE_W = 32,
  parameter int OUT_W   = 8,
  parameter int NUM_CH  = 16,
  parameter int CH_W    = 4
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clear,
  input  logic                      i_valid,
  input  logic signed [DATA_W-1:0]  i_act,
  input  logic signed [DATA_W-1:0]  i_wgt,
  input  logic                      i_last,
  input  logic                      i_cfg_we,
  input  logic [CH_W-1:0]           i_cfg_addr,
  input  logic [BIAS_W-1:0]         i_cfg_bias,
  input  logic [SCALE_W-1:0]        i_cfg_scale,
  input  logic [OUT_W-1:0]          i_cfg_zp,
  output logic                      o_valid,
  output logic signed [ACC_W-1:0]   o_acc,
  output logic [BIAS_W-1:0]         o_bias,
  output logic [SCALE_W-1:0]        o_scale,
  output logic [OUT_W-1:0]          o_zero_point,
  output logic [CH_W-1:0]           o_ch,
  output logic                      o_sat
);
  localparam int PROD_W = 2*DATA_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef struct packed {
    logic [BIAS_W-1:0]  bias;
    logic [SCALE_W-1:0] scale;
    logic [OUT_W-1:0]   zp;
  } param_t;

  param_t bank [NUM_CH];
  param_t cfg_wr;

  logic [1:0]               vld_pipe;
  logic                     s1_last;
  logic signed [PROD_W-1:0] s1_prod;
  logic signed [ACC_W-1:0]  acc;
  logic                     sat;
  logic [CH_W-1:0]          ch_cnt;

  logic signed [ACC_W:0]    sum_wide;
  logic signed [ACC_W-1:0]  sum;
  logic                     sum_sat;

  assign o_valid = vld_pipe[1];
  assign cfg_wr  = '{bias: i_cfg_bias, scale: i_cfg_scale, zp: i_cfg_zp};

  // One guard bit is enough: overflow shows as a mismatch of the top two bits.
  always_comb begin
    sum_wide = $signed({acc[ACC_W-1], acc})
             + $signed({{(ACC_W+1-PROD_W){s1_prod[PROD_W-1]}}, s1_prod});
    sum_sat  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    sum      = sum_wide[ACC_W-1:0];
    if (sum_sat) sum = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe     <= '0;
      s1_last      <= 1'b0;
      s1_prod      <= '0;
      acc          <= '0;
      sat          <= 1'b0;
      ch_cnt       <= '0;
      o_acc        <= '0;
      o_bias       <= '0;
      o_scale      <= '0;
      o_zero_point <= '0;
      o_ch         <= '0;
      o_sat        <= 1'b0;
    end else if (i_clear) begin
      vld_pipe <= '0;
      acc      <= '0;
      sat      <= 1'b0;
      ch_cnt   <= '0;
    end else begin
      vld_pipe[0] <= i_valid;
      vld_pipe[1] <= vld_pipe[0] & s1_last;
      if (i_valid) begin
        s1_prod <= i_act * i_wgt;
        s1_last <= i_last;
      end
      if (vld_pipe[0]) begin
        if (s1_last) begin
          // Emit and restart in the same cycle so back-to-back vectors need no bubble.
          o_acc        <= sum;
          o_sat        <= sat | sum_sat;
          o_bias       <= bank[ch_cnt].bias;
          o_scale      <= bank[ch_cnt].scale;
          o_zero_point <= bank[ch_cnt].zp;
          o_ch         <= ch_cnt;
          acc          <= '0;
          sat          <= 1'b0;
          ch_cnt       <= (ch_cnt == CH_W'(NUM_CH-1)) ? '0 : ch_cnt + 1'b1;
        end else begin
          acc <= sum;
          sat <= sat | sum_sat;
        end
      end
    end
  end

  // Bank is read combinationally above, so a same-cycle write yields the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) bank[c] <= '0;
    end else if (i_cfg_we && (int'(i_cfg_addr) < NUM_CH)) begin
      bank[i_cfg_addr] <= cfg_wr;
    end
  end
endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Signed int8 dot-product accumulator that feeds the requantize/ReLU stage.
- Consumes a stream of activation/weight pairs, one per cycle, and accumulates their products into a saturating 32-bit sum.
- On each vector end (i_last), emits the sum together with that output channel's bias, scale and zero point, taken from an internal per-channel parameter bank.
- Output fields align one-to-one with the requantize stage's acc/bias/scale/zero_point/valid inputs.

Parameters:
- DATA_W, 8, activation and weight width (signed).
- ACC_W, 32, accumulator and o_acc width (signed).
- BIAS_W, 32, bias width.
- SCALE_W, 32, scale width.
- OUT_W, 8, zero-point width.
- NUM_CH, 16, number of output channels in the parameter bank.
- CH_W, 4, channel index width; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- i_clear, in, 1, synchronous flush of pipeline, accumulator and channel counter.
- i_valid, in, 1, i_act/i_wgt/i_last valid this cycle.
- i_act, in, DATA_W, signed activation.
- i_wgt, in, DATA_W, signed weight.
- i_last, in, 1, final pair of the current dot product.
- i_cfg_we, in, 1, parameter bank write enable.
- i_cfg_addr, in, CH_W, channel written.
- i_cfg_bias, in, BIAS_W, bias value to write.
- i_cfg_scale, in, SCALE_W, scale value to write.
- i_cfg_zp, in, OUT_W, zero point value to write.
- o_valid, out, 1, one-cycle pulse per completed dot product.
- o_acc, out, ACC_W, saturated signed sum.
- o_bias, out, BIAS_W, bias for o_ch.
- o_scale, out, SCALE_W, scale for o_ch.
- o_zero_point, out, OUT_W, zero point for o_ch.
- o_ch, out, CH_W, channel index of the current output.
- o_sat, out, 1, saturation occurred during this dot product.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0.
  - Internal valid flags, accumulator, sat flag and channel counter are 0.
  - Parameter bank entries are 0.
- Stage 1: on i_valid, register prod = i_act*i_wgt (signed, 2*DATA_W bits), last flag and valid flag.
- Stage 2: when the stage-1 product is valid, sum = acc + sign-extended prod.
  - If sum exceeds 2**(ACC_W-1)-1 or falls below -2**(ACC_W-1), it clamps to that bound and sets the sat flag.
  - If the last flag is clear, the accumulator takes the sum.
  - If the last flag is set:
    - o_acc takes the sum, o_valid=1, o_sat = sat flag OR saturation this cycle.
    - o_bias, o_scale and o_zero_point take bank[ch_cnt]; o_ch takes ch_cnt.
    - The accumulator and sat flag are then zeroed, so the next pair starts a fresh sum without a bubble.
- Latency: o_valid is high on the 2nd rising edge after the edge that samples i_valid&i_last.
- o_valid is a single-cycle pulse. The data outputs hold their values until the next o_valid.
- Gaps (i_valid=0) between pairs of a vector are allowed and preserve the accumulator.
- A vector of length 1 (i_last on its first pair) is legal: o_acc = that product.
- Channel counter:
  - Increments on each emitted result.
  - Wraps from NUM_CH-1 to 0.
- Parameter bank:
  - Writes are registered on i_cfg_we; addresses >= NUM_CH are ignored.
  - The bank read happens in the emitting cycle. A write to the same channel in that same cycle is not visible; the old value is output.
  - Writes in any earlier cycle are visible.
- i_clear:
  - Zeroes the stage-1 valid flag, accumulator, sat flag and ch_cnt, and forces o_valid=0 on the following cycle.
  - Takes priority over all data inputs in the same cycle.
  - Does not alter the parameter bank or the held output data.
- Reset asserted mid-vector discards the partial sum. After release, the first emitted result is channel 0.
- No backpressure: the downstream stage always accepts o_valid.

Test Plan:
- Reset release, load ch0 = {bias=100, scale=0x4000_0000, zp=-3}, stream (2,3),(−4,5),(7,−1) with i_last on the third pair -> 2 cycles later o_valid=1, o_acc=−21, o_bias=100, o_scale=0x4000_0000, o_zero_point=−3, o_ch=0, o_sat=0.
- 18 back-to-back 4-pair vectors of (1,1) with no gaps -> 18 pulses, each o_acc=4; o_ch runs 0..15,0,1; no bubbles between results.
- Force saturation: 140000 pairs of (−128,−128), last on the final pair -> o_acc=2147483647, o_sat=1; the next vector (5,5) last -> o_acc=25, o_sat=0.
- Gaps: (10,10), idle 3 cycles, (−1,1) last -> o_acc=99. Length-1 vector (−128,127) -> o_acc=−16256.
- Write ch1 bias=7 in the cycle the ch1 result emits -> o_bias equals the old ch1 value. The next ch1 result shows 7.
- i_clear asserted mid-vector after (9,9) -> no o_valid; the next vector (1,2) last -> o_acc=2, o_ch=0. Async rst_n pulse mid-vector gives the same restart, with every output reading 0 during reset.
